// File: rtl/eprisc_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eprisc_serial_pkg
// Description : Shared types and constants for the EPRISC serial receiver:
//               FSM state encoding, 8N1 data-bit count and FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package eprisc_serial_pkg;

  // Receiver FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_STOP     = 3'd3,
    ST_WAITHIGH = 3'd4
  } rxState_t;

  // Data bits per 8N1 frame
  localparam int c_DATA_BITS  = 8;

  // Receive buffer depth when the FIFO option is built in
  localparam int c_FIFO_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/eprisc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eprisc_rx_fifo
// Description : Receive byte buffer with push/pop/full/empty. DEPTH==1 builds
//               a single holding register; larger depths build a ring FIFO.
//               A pop frees space for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module eprisc_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic             o_full,
  output logic             o_empty
);

  logic w_popEn;
  logic w_pushEn;

  generate
    if (DEPTH == 1) begin : g_single
      logic [WIDTH-1:0] r_data;
      logic             r_valid;

      assign w_popEn  = i_pop & r_valid;
      assign w_pushEn = i_push & (~r_valid | w_popEn);

      // Holding register: a push (possibly replacing a popped byte) wins over a pop
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (w_pushEn) begin
          r_data  <= i_pushData;
          r_valid <= 1'b1;
        end else if (w_popEn) begin
          r_valid <= 1'b0;
        end
      end

      assign o_headData = r_data;
      assign o_full     = r_valid;
      assign o_empty    = ~r_valid;
    end else begin : g_multi
      localparam int c_PTR_W = $clog2(DEPTH);
      localparam int c_CNT_W = $clog2(DEPTH + 1);
      localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
      localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

      logic [WIDTH-1:0]   r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_rdPtr;
      logic [c_PTR_W-1:0] r_wrPtr;
      logic [c_CNT_W-1:0] r_count;

      assign o_full   = (r_count == c_CNT_FULL);
      assign o_empty  = (r_count == '0);
      assign w_popEn  = i_pop & ~o_empty;
      assign w_pushEn = i_push & (~o_full | w_popEn);

      // Ring buffer: write slot, read slot and occupancy
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
          r_rdPtr <= '0;
          r_wrPtr <= '0;
          r_count <= '0;
        end else begin
          if (w_pushEn) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= (r_wrPtr == c_PTR_LAST) ? '0 : r_wrPtr + 1'b1;
          end
          if (w_popEn) begin
            r_rdPtr <= (r_rdPtr == c_PTR_LAST) ? '0 : r_rdPtr + 1'b1;
          end
          if (w_pushEn && !w_popEn) begin
            r_count <= r_count + c_CNT_W'(1);
          end else if (w_popEn && !w_pushEn) begin
            r_count <= r_count - c_CNT_W'(1);
          end
        end
      end

      assign o_headData = r_mem[r_rdPtr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/eprisc_ttl_receiver.sv
`default_nettype none
// ============================================================================
// Module      : eprisc_ttl_receiver
// Description : 8N1 TTL serial receiver, LSB first, with start-bit glitch
//               rejection, frame-error and overrun pulses and a receive
//               buffer presented as a valid/ready byte stream.
//               Build option EPRISC_TTL_RECEIVER_FIFO_EN selects a 4-entry
//               FIFO; otherwise a single holding register is used.
// Revision    : 1.0 - initial release
// ============================================================================
module eprisc_ttl_receiver
  import eprisc_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 256
) (
  input  logic       iBoardClock,
  input  logic       iBoardReset,
  input  logic       iTTLSerialRX,
  output logic [7:0] oRxData,
  output logic       oRxValid,
  input  logic       iRxReady,
  output logic       oFrameError,
  output logic       oOverrun,
  output logic       oBusy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = $clog2(c_DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_DATA_BITS - 1);
`ifdef EPRISC_TTL_RECEIVER_FIFO_EN
  localparam int c_BUF_DEPTH = c_FIFO_DEPTH;
`else
  localparam int c_BUF_DEPTH = 1;
`endif

  logic                   r_rxMeta;
  logic                   r_rxSync;
  logic [1:0]             r_flush;
  logic                   r_armed;
  rxState_t               r_state;
  logic [c_CNT_W-1:0]     r_clkCount;
  logic [c_IDX_W-1:0]     r_bitIdx;
  logic [c_DATA_BITS-1:0] r_shift;
  logic                   r_frameError;
  logic                   r_overrun;

  logic w_rxs;
  logic w_bitEnd;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  assign w_rxs    = r_rxSync;
  assign w_bitEnd = (r_clkCount == c_BIT_LAST);
  assign w_push   = (r_state == ST_STOP) && w_bitEnd && w_rxs;
  assign w_pop    = iRxReady & ~w_empty;

  // Two-flop synchronizer plus an arm flag: after reset the line must be seen
  // high (once the synchronizer has flushed its reset value) before a falling
  // edge may start a frame, so a line held low across reset never triggers
  always_ff @(posedge iBoardClock) begin
    if (iBoardReset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_flush  <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_rxMeta <= iTTLSerialRX;
      r_rxSync <= r_rxMeta;
      r_flush  <= {r_flush[0], 1'b1};
      if (r_flush[1] && w_rxs) r_armed <= 1'b1;
    end
  end

  // Receive FSM with bit timing, data shift and one-cycle status pulses
  always_ff @(posedge iBoardClock) begin
    if (iBoardReset) begin
      r_state      <= ST_IDLE;
      r_clkCount   <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_frameError <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frameError <= 1'b0;
      r_overrun    <= w_push & w_full & ~w_pop;
      case (r_state)
        ST_IDLE: begin
          if (r_armed && !w_rxs) begin
            r_state    <= ST_START;
            r_clkCount <= '0;
            r_bitIdx   <= '0;
          end
        end
        ST_START: begin
          if (r_clkCount == c_HALF_LAST) begin
            r_clkCount <= '0;
            r_state    <= w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_clkCount <= r_clkCount + c_CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bitEnd) begin
            r_shift[r_bitIdx] <= w_rxs;
            r_clkCount        <= '0;
            r_bitIdx          <= r_bitIdx + c_IDX_W'(1);
            if (r_bitIdx == c_IDX_LAST) r_state <= ST_STOP;
          end else begin
            r_clkCount <= r_clkCount + c_CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (w_bitEnd) begin
            r_clkCount <= '0;
            if (w_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_frameError <= 1'b1;
              r_state      <= ST_WAITHIGH;
            end
          end else begin
            r_clkCount <= r_clkCount + c_CNT_W'(1);
          end
        end
        ST_WAITHIGH: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  eprisc_rx_fifo #(
    .DEPTH (c_BUF_DEPTH),
    .WIDTH (c_DATA_BITS)
  ) uRxFifo (
    .clk        (iBoardClock),
    .rst        (iBoardReset),
    .i_push     (w_push),
    .i_pushData (r_shift),
    .i_pop      (iRxReady),
    .o_headData (oRxData),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign oRxValid    = ~w_empty;
  assign oFrameError = r_frameError;
  assign oOverrun    = r_overrun;
  assign oBusy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
